bcd_serial_addsub: RTL
======================

BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 Parameter DIGITS, default 3: number of BCD digits per operand; legal range 1..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset; one clock domain only.
REQ-004 start  input  1  request to begin an operation; sampled on clk when busy=0.
REQ-005 sub  input  1  operation select: 0 = A+B, 1 = A-B; sampled with start.
REQ-006 A  input  4*DIGITS  minuend/addend, packed BCD, digit 0 in bits [3:0].
REQ-007 B  input  4*DIGITS  subtrahend/addend, packed BCD, same layout as A.
REQ-008 busy  output  1  high while digits are being processed.
REQ-009 done  output  1  one-cycle pulse when Sum, Cout, neg and err are valid.
REQ-010 Sum  output  4*DIGITS  registered packed BCD result.
REQ-011 Cout  output  1  final decimal carry out of digit DIGITS-1.
REQ-012 neg  output  1  subtraction result negative (A<B).
REQ-013 err  output  1  at least one operand digit was greater than 9.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE/DONE + start=1 -> RUN; capture A, B and sub; clear the digit index; set the carry register to sub; clear the Sum register.
REQ-016 In IDLE and DONE, start=0 SHALL leave the outputs unchanged; DONE SHALL always return to IDLE after one cycle unless start=1.
REQ-017 RUN SHALL process one digit per clock, from digit 0 (LSD) upward.
REQ-018 Each RUN digit step SHALL compute a_i + b'_i + carry, where b'_i = b_i for add and 9-b_i for sub.
REQ-019 If that raw 5-bit sum exceeds 9, the step SHALL add 6, keep the low 4 bits as the digit and set carry=1; otherwise the digit is the raw sum and carry=0.
REQ-020 The resulting digit SHALL be written to Sum[4i+3:4i], and the digit index SHALL increment.
REQ-021 After the step for digit DIGITS-1, RUN -> DONE; done=1 during the DONE cycle only.
REQ-022 Latency: done SHALL be high in the cycle following the DIGITS-th rising edge after the start-accepting edge.
REQ-023 Cout SHALL be the carry left after the final digit step.
REQ-024 In sub mode, Cout=1 means no borrow, neg=~Cout, and Sum holds the raw ten's complement (e.g. 130-558 -> 572, neg=1).
REQ-025 In add mode, neg SHALL be 0.
REQ-026 err SHALL be evaluated on the captured operands: any nibble of A or B greater than 9 sets err=1.
REQ-027 When err=1, Sum, Cout and neg SHALL all read 0 at done; the operation still takes the full DIGITS cycles.
REQ-028 busy SHALL be 1 exactly while in RUN.
REQ-029 start SHALL be ignored while busy=1; changes on A, B or sub during RUN SHALL NOT affect the result.
REQ-030 Sum, Cout, neg and err SHALL hold their last values until the next accepted start.
REQ-031 Cout, neg and err SHALL update only on entry to DONE; Sum digits update as computed.
REQ-032 start held high SHALL begin back-to-back operations, with one DONE cycle between each.
REQ-033 A DIGITS=1 configuration SHALL produce done one cycle after the start-accepting edge.

Reset
REQ-034 rst=1 SHALL force the IDLE state asynchronously, without waiting for a clock edge.
REQ-035 rst=1 SHALL clear Sum, Cout, neg, err, busy, done, the carry register and the digit index to 0.
REQ-036 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification (DIGITS=3)
REQ-037 A=0x124, B=0x076, sub=0 -> done 3 cycles after start; Sum=0x200, Cout=0, neg=0, err=0.
REQ-038 A=0x999, B=0x001, sub=0 -> Sum=0x000, Cout=1; then A=0x558, B=0x130 -> Sum=0x688, Cout=0.
REQ-039 A=0x558, B=0x130, sub=1 -> Sum=0x428, Cout=1, neg=0; then A=0x130, B=0x558, sub=1 -> Sum=0x572, Cout=0, neg=1.
REQ-040 A=0x1A0, B=0x005 -> err=1, Sum=0x000, Cout=0 at done; a following valid operation clears err.
REQ-041 Start pulsed again while busy=1 -> ignored; rst asserted mid-RUN -> outputs 0 immediately, no done pulse; a later start of 0x018+0x288 gives Sum=0x306.

Source files
------------

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub
//   Digit-serial packed-BCD adder/subtractor. One BCD digit is processed per
//   clock, least significant digit first. Subtraction is done as
//   A + (9's complement of B) + 1, so a borrow-free result leaves Cout=1 and a
//   negative result leaves the raw ten's complement in Sum with neg=1.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : begin an operation (sampled when not busy)
//   sub    : 0 = A+B, 1 = A-B (sampled with start)
//   A, B   : packed BCD operands, digit 0 in bits [3:0]
//   busy   : high while digits are being processed
//   done   : one-cycle pulse when Sum/Cout/neg/err are valid
//   Sum    : packed BCD result
//   Cout   : decimal carry out of the top digit (no-borrow flag in sub mode)
//   neg    : subtraction result negative
//   err    : an operand digit was greater than 9
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start, outputs hold last result
// S_RUN  | one digit per clock, digit index counts up from 0
// S_DONE | result valid for one cycle, start here chains a new op

module bcd_serial_addsub #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   Sum,
    output logic                  Cout,
    output logic                  neg,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               neg_q, neg_d;
    logic               err_q, err_d;

    logic [3:0]         a_dig;
    logic [3:0]         b_dig;
    logic [3:0]         b_eff;
    logic [4:0]         raw;
    logic [3:0]         dig;
    logic               carry_nx;
    logic               bad_opnd;

    // Any non-BCD nibble in the captured operands poisons the whole result.
    always_comb begin
        bad_opnd = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a_q[4*i +: 4] > 4'd9) || (b_q[4*i +: 4] > 4'd9)) begin
                bad_opnd = 1'b1;
            end
        end
    end

    // Single-digit BCD add. raw tops out at 31 even for bad digits, so 5 bits
    // suffice; adding 6 in 4 bits yields the corrected low nibble directly.
    always_comb begin
        a_dig = a_q[4*idx_q +: 4];
        b_dig = b_q[4*idx_q +: 4];
        b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
        raw   = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
        if (raw > 5'd9) begin
            dig      = raw[3:0] + 4'd6;
            carry_nx = 1'b1;
        end else begin
            dig      = raw[3:0];
            carry_nx = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        neg_d   = neg_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = A;
                    b_d     = B;
                    sub_d   = sub;
                    idx_d   = '0;
                    carry_d = sub;
                    sum_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[4*idx_q +: 4] = bad_opnd ? 4'd0 : dig;
                carry_d = carry_nx;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    cout_d  = carry_nx & ~bad_opnd;
                    neg_d   = sub_q & ~carry_nx & ~bad_opnd;
                    err_d   = bad_opnd;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign neg  = neg_q;
    assign err  = err_q;

endmodule
